// File: rtl/seg7_word_decoder.sv
// -----------------------------------------------------------------------------
// seg7_word_decoder
//
// Collects five active-low 7-segment patterns (display positions 5 down to 1)
// through a valid/ready handshake. It matches the assembled word against a
// small table of product words and presents the product code, a match flag
// and a discount flag through a second valid/ready handshake. It also keeps a
// saturating count of results taken by the consumer.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   clear       synchronous abort: drop held symbols and any pending result
//   seg_in      7-segment pattern {g,f,e,d,c,b,a}, active-low (blank = 7'h7F)
//   in_valid    seg_in carries a symbol
//   in_ready    block accepts a symbol this cycle
//   upc         product code of the matched word (0 on a miss)
//   match       received word equals a table entry
//   discount    discount flag for upc
//   out_valid   upc/match/discount are valid
//   out_ready   consumer takes the result
//   word_count  number of results consumed, saturates at 255
// -----------------------------------------------------------------------------
module seg7_word_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [6:0] seg_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] upc,
    output logic       match,
    output logic       discount,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] word_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

    // Word is {pos5, pos4, pos3, pos2, pos1}; result is {match, upc}.
    function automatic logic [3:0] lookup(input logic [34:0] word);
        case (word)
            {7'h03, 7'h08, 7'h47, 7'h47, 7'h7F}: lookup = 4'b1_000; // bALL
            {7'h46, 7'h2F, 7'h23, 7'h27, 7'h12}: lookup = 4'b1_001; // CrocS
            {7'h79, 7'h10, 7'h47, 7'h23, 7'h23}: lookup = 4'b1_010; // lgLoo
            {7'h21, 7'h2F, 7'h06, 7'h12, 7'h12}: lookup = 4'b1_101; // drESS
            {7'h46, 7'h0B, 7'h06, 7'h12, 7'h12}: lookup = 4'b1_110; // ChESS
            {7'h10, 7'h23, 7'h47, 7'h21, 7'h7F}: lookup = 4'b1_111; // goLd
            default:                             lookup = 4'b0_000;
        endcase
    endfunction

    function automatic logic discount_of(input logic m, input logic [2:0] u);
        return m & ((~u[2] & ~u[1]) | (u[2] & ~u[0]));
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  pos_q, pos_d;      // symbols currently held (0..4)
    logic [27:0] sym_q;             // last four accepted symbols, oldest in MSBs
    logic        in_ready_q;
    logic [2:0]  upc_q;
    logic        match_q;
    logic        disc_q;
    logic [7:0]  wc_q;

    logic        xfer;
    logic        consume;
    logic        last_xfer;
    logic [3:0]  hit;

    assign out_valid  = (state_q == RESULT);
    assign in_ready   = in_ready_q;
    assign upc        = upc_q;
    assign match      = match_q;
    assign discount   = disc_q;
    assign word_count = wc_q;

    assign xfer      = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;
    assign last_xfer = xfer & (state_q == COLLECT) & (pos_q == 3'd4);
    assign hit       = lookup({sym_q, seg_in});

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (clear) begin
            state_d = IDLE;
            pos_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = COLLECT;
                        pos_d   = 3'd1;
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        if (pos_q == 3'd4) begin
                            state_d = RESULT;
                            pos_d   = 3'd0;
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end
                end
                RESULT: begin
                    if (consume) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    pos_d   = 3'd0;
                end
            endcase
        end
    end

    // Control and result registers. in_ready is registered so it stays low
    // throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pos_q      <= 3'd0;
            in_ready_q <= 1'b0;
            upc_q      <= 3'd0;
            match_q    <= 1'b0;
            disc_q     <= 1'b0;
            wc_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            in_ready_q <= (state_d != RESULT);
            if (clear || consume) begin
                // Result fields read as zero whenever no result is presented.
                upc_q   <= 3'd0;
                match_q <= 1'b0;
                disc_q  <= 1'b0;
            end else if (last_xfer) begin
                upc_q   <= hit[2:0];
                match_q <= hit[3];
                disc_q  <= discount_of(hit[3], hit[2:0]);
            end
            if (!clear && consume && (wc_q != 8'hFF)) wc_q <= wc_q + 8'd1;
        end
    end

    // Symbol history is pure data; the position counter decides what is valid.
    always_ff @(posedge clk) begin
        if (xfer && !clear) sym_q <= {sym_q[20:0], seg_in};
    end

endmodule

// File: tb/tb_seg7_word_decoder.sv
module tb_seg7_word_decoder;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic [6:0] seg_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] upc;
    logic       match;
    logic       discount;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] word_count;

    seg7_word_decoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .seg_in     (seg_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .upc        (upc),
        .match      (match),
        .discount   (discount),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] upc;
        logic       match;
        logic       discount;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   wc_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compares presented results and pops on consume.
    always @(negedge clk) begin
        check("valid_vs_scoreboard", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
        if (out_valid && sb.size() != 0) begin
            check("upc",      {29'd0, upc},      {29'd0, sb[0].upc});
            check("match",    {31'd0, match},    {31'd0, sb[0].match});
            check("discount", {31'd0, discount}, {31'd0, sb[0].discount});
            if (out_ready) begin
                void'(sb.pop_front());
                if (wc_exp != 255) wc_exp++;
            end
        end else if (!out_valid) begin
            check("idle_fields_zero", {27'd0, upc, match, discount}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic xfer(input logic [6:0] s);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        seg_in   = s;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seg_in   = 7'h7F;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [34:0] w, input logic [2:0] eu,
                             input logic em, input logic ed, input bit gaps);
        exp_t e;
        logic [34:0] t;
        t = w;
        for (int i = 0; i < 5; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            xfer(t[34:28]);
            t = {t[27:0], 7'h00};
        end
        e.upc = eu; e.match = em; e.discount = ed;
        sb.push_back(e);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        seg_in    = 7'h7F;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_outputs", {20'd0, word_count, upc, match, discount},  32'd0);
        check("rst_valid_ready", {30'd0, out_valid, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

        // drESS, consumed immediately
        send_word({7'h21, 7'h2F, 7'h06, 7'h12, 7'h12}, 3'b101, 1'b1, 1'b0, 1'b0);
        drain();
        check("word_count_1", {24'd0, word_count}, 32'd1);

        // ChESS held with out_ready low
        out_ready = 1'b0;
        send_word({7'h46, 7'h0B, 7'h06, 7'h12, 7'h12}, 3'b110, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("in_ready_hold", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("word_count_2", {24'd0, word_count}, 32'd2);

        // Unused code in position 1 gives a miss
        send_word({7'h03, 7'h08, 7'h47, 7'h47, 7'h00}, 3'b000, 1'b0, 1'b0, 1'b0);
        drain();

        // Clear during collection, then goLd
        xfer(7'h46);
        xfer(7'h2F);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sb.delete();
        check("clear_no_valid", {31'd0, out_valid}, 32'd0);
        check("clear_keeps_count", {24'd0, word_count}, 32'd3);
        send_word({7'h10, 7'h23, 7'h47, 7'h21, 7'h7F}, 3'b111, 1'b1, 1'b0, 1'b0);
        drain();
        check("one_result_after_clear", {24'd0, word_count}, 32'd4);

        // lgLoo with gaps in in_valid
        send_word({7'h79, 7'h10, 7'h47, 7'h23, 7'h23}, 3'b010, 1'b1, 1'b0, 1'b1);
        drain();

        // CrocS for the remaining table entry
        send_word({7'h46, 7'h2F, 7'h23, 7'h27, 7'h12}, 3'b001, 1'b1, 1'b1, 1'b0);
        drain();
        check("word_count_6", {24'd0, word_count}, 32'd6);

        // Reset dropped mid-word
        xfer(7'h79);
        xfer(7'h10);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_fields", {20'd0, word_count, upc, match, discount}, 32'd0);
        check("midreset_valid_ready", {30'd0, out_valid, in_ready}, 32'd0);
        wc_exp = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midreset", {31'd0, in_ready}, 32'd1);
        send_word({7'h10, 7'h23, 7'h47, 7'h21, 7'h7F}, 3'b111, 1'b1, 1'b0, 1'b0);
        drain();
        check("count_after_midreset", {24'd0, word_count}, 32'd1);

        // Saturation of word_count
        for (int k = 0; k < 256; k++) begin
            send_word({7'h03, 7'h08, 7'h47, 7'h47, 7'h7F}, 3'b000, 1'b1, 1'b1, 1'b0);
        end
        drain();
        check("word_count_sat", {24'd0, word_count}, 32'd255);
        check("word_count_model", {24'd0, word_count}, wc_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
